fb_scan_reader: RTL and testbench

Reads the 160x120 framebuffer back out in raster order: issues read addresses to the video RAM's read port, absorbs the RAM's one-cycle read latency and presents a valid/ready pixel stream tagged with coordinates and frame/line markers. It is the read-side counterpart of the screen-clear/draw writers that fill video memory. Consumers are collision checks, frame dump and any downstream pixel processor.

---
 rtl/fb_pkg.sv | 33 +++
 rtl/fb_scan_reader_if.sv | 31 +++
 rtl/pix_skid_fifo.sv | 47 ++++
 rtl/fb_scan_reader.sv | 125 ++++++++++++
 tb/tb_fb_scan_reader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan reader.
package fb_pkg;

    localparam int unsigned WIDTH    = 160;
    localparam int unsigned HEIGHT   = 120;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain
    } state_e;

    typedef struct packed {
        logic [COLOUR_W-1:0] colour;
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic                sof;
        logic                eol;
    } pix_tag_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_scan_reader_if.sv
// Control, video RAM read port and pixel stream of the scan reader.
interface fb_scan_reader_if;
    import fb_pkg::*;

    logic                start;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [COLOUR_W-1:0] rd_data;
    logic                pix_valid;
    logic                pix_ready;
    logic [COLOUR_W-1:0] pix_colour;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic                pix_sof;
    logic                pix_eol;

    modport master (
        input  start, rd_data, pix_ready,
        output busy, done, rd_en, rd_addr,
        output pix_valid, pix_colour, pix_x, pix_y, pix_sof, pix_eol
    );

    modport slave (
        output start, rd_data, pix_ready,
        input  busy, done, rd_en, rd_addr,
        input  pix_valid, pix_colour, pix_x, pix_y, pix_sof, pix_eol
    );

endinterface

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel FIFO between the RAM return path and the output stream.
module pix_skid_fifo
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_push,
    input  pix_tag_t   i_tag,
    output logic       o_valid,
    input  logic       i_ready,
    output pix_tag_t   o_tag,
    output logic [1:0] o_count
);
    pix_tag_t   r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_tag   = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_tag;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/fb_scan_reader.sv
// Raster-order framebuffer read-out: issues video RAM reads, absorbs the one-cycle
// read latency and presents a coordinate-tagged valid/ready pixel stream.
module fb_scan_reader
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    fb_scan_reader_if.master bus
);
    state_e         r_state;
    state_e         w_state_next;
    logic [X_W-1:0] r_ix;
    logic [Y_W-1:0] r_iy;
    logic           r_inflight;
    logic [X_W-1:0] r_fl_x;
    logic [Y_W-1:0] r_fl_y;
    logic           r_done;
    logic           w_done_next;

    logic       w_fifo_valid;
    logic       w_pop;
    logic       w_issue;
    logic       w_last_issue;
    logic       w_last_pop;
    logic [1:0] w_count;
    logic [2:0] w_occ;
    pix_tag_t   w_push_tag;
    pix_tag_t   w_head;

    // Credit check: the FIFO must have room for every read already in the pipe.
    assign w_pop        = w_fifo_valid && bus.pix_ready;
    assign w_occ        = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = (r_state == StScan) && (w_occ < 3'd2);
    assign w_last_issue = w_issue && (r_ix == X_LAST) && (r_iy == Y_LAST);
    assign w_last_pop   = w_pop && (w_head.x == X_LAST) && (w_head.y == Y_LAST);

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StScan;
            StScan:  if (w_last_issue) w_state_next = StDrain;
            StDrain: begin
                if (w_last_pop) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ix <= '0;
            r_iy <= '0;
        end else if ((r_state == StIdle) && bus.start) begin
            r_ix <= '0;
            r_iy <= '0;
        end else if (w_issue) begin
            if (r_ix == X_LAST) begin
                r_ix <= '0;
                r_iy <= (r_iy == Y_LAST) ? '0 : r_iy + 1'b1;
            end else begin
                r_ix <= r_ix + 1'b1;
            end
        end
    end

    // Coordinates of the read whose data appears on rd_data this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inflight <= 1'b0;
            r_fl_x     <= '0;
            r_fl_y     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fl_x <= r_ix;
                r_fl_y <= r_iy;
            end
        end
    end

    always_comb begin
        w_push_tag.colour = bus.rd_data;
        w_push_tag.x      = r_fl_x;
        w_push_tag.y      = r_fl_y;
        w_push_tag.sof    = (r_fl_x == '0) && (r_fl_y == '0);
        w_push_tag.eol    = (r_fl_x == X_LAST);
    end

    pix_skid_fifo u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (r_inflight),
        .i_tag   (w_push_tag),
        .o_valid (w_fifo_valid),
        .i_ready (bus.pix_ready),
        .o_tag   (w_head),
        .o_count (w_count)
    );

    assign bus.busy       = (r_state != StIdle);
    assign bus.done       = r_done;
    assign bus.rd_en      = w_issue;
    assign bus.rd_addr    = pix_addr(r_ix, r_iy);
    assign bus.pix_valid  = w_fifo_valid;
    assign bus.pix_colour = w_head.colour;
    assign bus.pix_x      = w_head.x;
    assign bus.pix_y      = w_head.y;
    assign bus.pix_sof    = w_head.sof;
    assign bus.pix_eol    = w_head.eol;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: raster-sequence model checked every cycle plus directed scenarios.
module tb_fb_scan_reader;
    import fb_pkg::*;

    localparam int NPIX = WIDTH * HEIGHT;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    fb_scan_reader_if bus();

    fb_scan_reader dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Video RAM with one-cycle read latency.
    logic [COLOUR_W-1:0] mem [NPIX];
    int pattern = 0;

    function automatic logic [COLOUR_W-1:0] colour_of(input int a);
        if (pattern == 0) return COLOUR_W'(a % 8);
        return COLOUR_W'((a ^ (a >> 3) ^ (a >> 7) ^ (a >> 11)) & 7);
    endfunction

    task automatic load_mem();
        for (int a = 0; a < NPIX; a++) mem[a] = colour_of(a);
    endtask

    always @(posedge clk) begin
        if (bus.rd_en && (int'(bus.rd_addr) < NPIX)) bus.rd_data <= mem[bus.rd_addr];
    end

    // pix_ready: 0 hold low, 1 high, 2 random, 3 high except a 100-cycle stall at (37,5).
    int ready_mode = 0;
    int stall_used = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: bus.pix_ready = 1'b0;
            1: bus.pix_ready = 1'b1;
            2: bus.pix_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bus.pix_valid && bus.pix_x == 8'd37 && bus.pix_y == 7'd5 && stall_used < 100) begin
                    bus.pix_ready = 1'b0;
                    stall_used++;
                end else begin
                    bus.pix_ready = 1'b1;
                end
            end
        endcase
    end

    // Model: pixels leave in raster index order; reads are issued in the same order.
    int n_issued = 0;
    int n_accepted = 0;
    int frames_done = 0;
    int start_cyc = 0;
    int last_addr = -1;
    bit m_busy = 0;
    bit m_last_prev = 0;
    bit m_last_now = 0;
    bit m_stall_prev = 0;
    bit m_seen_first = 1;
    bit m_full_rate = 0;
    bit m_pop = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            n_issued     = 0;
            n_accepted   = 0;
            m_busy       = 0;
            m_last_prev  = 0;
            m_stall_prev = 0;
            m_seen_first = 1;
            m_full_rate  = 0;
        end else begin
            m_pop = bus.pix_valid && bus.pix_ready;
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_last_prev);
            if (bus.done) begin
                frames_done++;
                if (m_full_rate) check("frame_cycles", cyc - start_cyc, NPIX + 2);
            end
            if (m_stall_prev) check("stall_hold_valid", bus.pix_valid, 1);
            if (bus.pix_valid) begin
                check("pix_has_source", n_accepted < n_issued, 1);
                check("pix_x", bus.pix_x, n_accepted % WIDTH);
                check("pix_y", bus.pix_y, n_accepted / WIDTH);
                check("pix_colour", bus.pix_colour, colour_of(n_accepted));
                check("pix_sof", bus.pix_sof, n_accepted == 0);
                check("pix_eol", bus.pix_eol, (n_accepted % WIDTH) == WIDTH - 1);
                if (!m_seen_first) begin
                    check("first_latency", cyc - start_cyc, 2);
                    m_seen_first = 1;
                end
            end
            if (bus.rd_en) begin
                check("rd_when_busy", m_busy, 1);
                check("rd_addr", bus.rd_addr, n_issued);
                check("rd_in_frame", n_issued < NPIX, 1);
                check("rd_credit", (n_issued - n_accepted - int'(m_pop)) < 2, 1);
                last_addr = int'(bus.rd_addr);
                n_issued++;
            end
            m_last_now = m_pop && (n_accepted == NPIX - 1);
            if (m_pop) n_accepted++;
            if (m_busy && !bus.pix_ready) m_full_rate = 0;
            if (!m_busy && bus.start) begin
                m_busy       = 1;
                start_cyc    = cyc + 1;
                n_issued     = 0;
                n_accepted   = 0;
                m_seen_first = 0;
                m_full_rate  = 1;
            end else if (m_last_now) begin
                m_busy = 0;
            end
            m_stall_prev = bus.pix_valid && !bus.pix_ready;
            m_last_prev  = m_last_now;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_valid"}, bus.pix_valid, 0);
        check({tag, "_colour"}, bus.pix_colour, 0);
        check({tag, "_x"}, bus.pix_x, 0);
        check({tag, "_y"}, bus.pix_y, 0);
        check({tag, "_sof"}, bus.pix_sof, 0);
        check({tag, "_eol"}, bus.pix_eol, 0);
    endtask

    int c0;
    bit hit;

    initial begin
        bus.start = 1'b0;
        pattern = 0;
        load_mem();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;
        ready_mode = 1;

        // Frame 1: full rate, stray starts while busy.
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        c0 = cyc;
        check("f1_busy", bus.busy, 1);
        check("f1_rd_en", bus.rd_en, 1);
        check("f1_rd_addr0", bus.rd_addr, 0);
        @(posedge clk); #1;
        check("f1_no_pix_yet", bus.pix_valid, 0);
        @(posedge clk); #1;
        check("f1_pix_valid", bus.pix_valid, 1);
        check("f1_sof", bus.pix_sof, 1);
        check("f1_colour0", bus.pix_colour, 0);
        repeat (3) begin
            repeat (500) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        hit = 0;
        for (int i = 0; i < 25000; i++) begin
            @(posedge clk); #1;
            if (bus.pix_valid && bus.pix_x == 8'd159 && bus.pix_y == 7'd119) begin
                hit = 1;
                break;
            end
        end
        check("f1_reach_last", hit, 1);
        check("f1_last_eol", bus.pix_eol, 1);
        check("f1_last_colour", bus.pix_colour, 19199 % 8);
        check("f1_drain_no_rd", bus.rd_en, 0);
        check("f1_last_addr", last_addr, 19199);
        // start across last acceptance (ignored) and the done cycle (taken).
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("f1_done", bus.done, 1);
        check("f1_busy_low", bus.busy, 0);
        check("f1_cycles", cyc - c0, 19202);
        ready_mode = 3;
        @(posedge clk); #1 bus.start = 1'b0;
        c0 = cyc;
        check("f2_busy", bus.busy, 1);
        check("f2_rd_addr0", bus.rd_addr, 0);
        @(posedge clk);
        @(posedge clk); #1;
        check("f2_first_pix", bus.pix_valid && bus.pix_sof, 1);
        check("f2_first_cyc", cyc - c0, 2);

        // Frame 2: stall at (37,5), then reset at (80,60).
        hit = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #3;
            if (stall_used >= 50) begin
                hit = 1;
                break;
            end
        end
        check("f2_reach_stall", hit, 1);
        check("f2_stall_valid", bus.pix_valid, 1);
        check("f2_stall_x", bus.pix_x, 37);
        check("f2_stall_y", bus.pix_y, 5);
        check("f2_stall_colour", bus.pix_colour, 5);
        check("f2_stall_no_rd", bus.rd_en, 0);
        check("f2_outstanding", (n_issued - n_accepted) <= 2, 1);
        hit = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (bus.pix_valid && bus.pix_x == 8'd80 && bus.pix_y == 7'd60) begin
                hit = 1;
                break;
            end
        end
        check("f2_reach_80_60", hit, 1);
        check("f2_stall_count", stall_used, 100);
        #3 resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        check("midreset_no_done", bus.done, 0);
        resetn = 1'b1;

        // Frame 3: random backpressure, different RAM contents.
        pattern = 1;
        load_mem();
        ready_mode = 2;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        hit = 0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (bus.done) begin
                hit = 1;
                break;
            end
        end
        check("f3_done_seen", hit, 1);
        @(posedge clk); #1;
        check("f3_busy_low", bus.busy, 0);
        check("f3_done_single", bus.done, 0);
        check("f3_accepted", n_accepted, NPIX);
        check("f3_last_addr", last_addr, 19199);
        check("frames_done", frames_done, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
